fcs_check: RTL and testbench
============================

Name: fcs_check

Overview:
- Serial CRC-32 frame checker. It is the receive-side counterpart of the tag's serial FCS generator.
- Consumes one bit per strobe, MSB-first, over a frame made of payload bits followed by the 32 transmitted FCS bits.
- Verifies the frame against the fixed CRC-32 residue and reports pass/fail plus the frame bit length.
- Sits after the bit slicer in the ice40 receive path and feeds the frame-accept logic.

Parameters:
- STATE_INIT_VAL, 32'hFFFFFFFF, CRC shift-register preset loaded at each frame start.
- RESIDUE, 32'hC704DD7B, register value after a good frame (message + complemented FCS, MSB-first, poly 0x04C11DB7).
- MIN_BITS, 32, minimum frame length in bits, FCS included; shorter frames are runts.
- CNT_W, 16, width of the frame_bits counter.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- valid  in  1  bit strobe; s_in, sof and eof are sampled only when valid=1.
- s_in  in  1  serial data bit, MSB-first.
- sof  in  1  first bit of a frame (qualified by valid).
- eof  in  1  last bit of a frame, i.e. the last FCS bit (qualified by valid).
- done  out  1  one-cycle pulse when a frame verdict is ready.
- fcs_ok  out  1  verdict; valid with done, held until the next done.
- runt  out  1  frame shorter than MIN_BITS; held like fcs_ok.
- aborted  out  1  one-cycle pulse when a sof arrives mid-frame.
- frame_bits  out  CNT_W  bit count of the last completed frame; held.
- crc_state  out  32  live CRC shift register, for debug.

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE and crc_state=STATE_INIT_VAL.
  - The internal bit counter, done, fcs_ok, runt, aborted and frame_bits all clear to 0.
- CRC step, nxt(c,b):
  - fb = c[31]^b.
  - nxt = {c[30:0],1'b0} ^ (fb ? 32'h04C11DB7 : 0).
  - This is the same LFSR as the generator.
- valid=0: no state change; s_in, sof and eof are ignored.
- IDLE:
  - valid&sof: crc<=nxt(STATE_INIT_VAL,s_in), cnt<=1, go to RUN.
  - valid&sof&eof: one-bit frame; go straight to the verdict with cnt=1, so runt=1 and fcs_ok=0.
  - valid without sof: ignored.
- RUN:
  - valid: crc<=nxt(crc,s_in). cnt<=cnt+1, saturating at all-ones; there is no wrap.
  - valid&eof (without sof): verdict on the next edge, then go to IDLE.
  - Verdict values:
    - done=1 for exactly one cycle.
    - frame_bits = cnt+1 (saturated).
    - runt = (cnt+1 < MIN_BITS).
    - fcs_ok = (nxt(crc,s_in) == RESIDUE) && !runt.
  - valid&sof: the current frame is dropped and aborted pulses for one cycle. The register restarts as in IDLE (crc<=nxt(STATE_INIT_VAL,s_in), cnt<=1), so the new bit counts as bit 1. No done is issued for the dropped frame.
  - valid&sof&eof in RUN: abort the old frame and treat the bit as a one-bit runt frame. Both aborted and done pulse in the same cycle.
- Latency: done rises on the edge after the edge that samples the eof bit. A back-to-back sof on the very next strobe is accepted.
- crc_state after a verdict:
  - Holds the final register value until the next sof.
  - Returns to STATE_INIT_VAL only on reset.
- Reset mid-frame: the frame is discarded and no done is issued.

Optional Feature:
- Macro: FCS_CHECK_STATS_EN.
- Defined:
  - Adds outputs good_cnt[15:0] and bad_cnt[15:0].
  - On each done: good_cnt++ if fcs_ok, otherwise bad_cnt++; both counters saturate at 16'hFFFF.
  - Aborted frames count in neither.
  - Both counters clear on rst.
- Undefined: the ports and the logic are absent.

Test Plan:
- Good frame:
  - Stimulus: sof on the first bit; ASCII "123456789" MSB-first (72 bits), then 32'hFC891918 MSB-first; eof on the last bit; valid every cycle.
  - Required response: done one cycle after eof, fcs_ok=1, runt=0, frame_bits=104, crc_state=32'hC704DD7B.
- Error frame: same frame with bit 5 inverted -> done, fcs_ok=0, runt=0, frame_bits=104.
- Empty-message frame and runt:
  - 32 zero bits (FCS of the empty message) with MIN_BITS=32 -> fcs_ok=1, frame_bits=32.
  - Same frame with MIN_BITS=40 -> runt=1, fcs_ok=0.
- Strobe gaps: good frame with valid toggling 1/0/0 per bit -> identical verdict to the continuous case; no state change on the valid=0 cycles.
- Abort: sof, 20 bits, then sof and the full good frame -> aborted pulses once, a single done with fcs_ok=1, frame_bits=104.
- Reset mid-frame: rst at bit 50 of the good frame, then the full good frame -> no done for the first frame; the second passes. With FCS_CHECK_STATS_EN, good_cnt=1 and bad_cnt=0.

Source files
------------

// File: rtl/fcs_check.sv
// Serial MSB-first CRC-32 frame checker: verifies payload+FCS against the fixed residue, reports verdict and frame length.
// Latency: done/fcs_ok/runt/frame_bits/aborted update on the second rising edge after the strobe carrying eof (or the aborting sof).
// Backpressure: none; every valid strobe is consumed. Optional FCS_CHECK_STATS_EN adds good_cnt/bad_cnt verdict counters.
module fcs_check #(
  parameter logic [31:0] STATE_INIT_VAL = 32'hFFFFFFFF,
  parameter logic [31:0] RESIDUE        = 32'hC704DD7B,
  parameter int          MIN_BITS       = 32,
  parameter int          CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic             s_in,
  input  logic             sof,
  input  logic             eof,
  output logic             done,
  output logic             fcs_ok,
  output logic             runt,
  output logic             aborted,
  output logic [CNT_W-1:0] frame_bits,
  output logic [31:0]      crc_state
`ifdef FCS_CHECK_STATS_EN
  ,
  output logic [15:0]      good_cnt,
  output logic [15:0]      bad_cnt
`endif
);

  localparam logic [31:0]      POLY    = 32'h04C11DB7;
  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_BITS);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [31:0]      crc_base, crc_nxt;
  logic             take, ends, drops;

  // Verdict computed on the eof strobe, published one edge later.
  logic             pend, pend_ok, pend_runt, pend_abort;
  logic [CNT_W-1:0] pend_bits;

  // One LFSR step, message bit entering at the top (same as the generator).
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic b);
    return {c[30:0], 1'b0} ^ ((c[31] ^ b) ? POLY : 32'h0);
  endfunction

  // Next state plus per-strobe decode: which register to step, counter update, frame end/abort.
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    ends      = 1'b0;
    drops     = 1'b0;
    crc_base  = crc_state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (valid && sof) begin
          take      = 1'b1;
          ends      = eof;
          crc_base  = STATE_INIT_VAL;
          cnt_nxt   = ONE_CNT;
          state_nxt = eof ? IDLE : RUN;
        end
      end
      RUN: begin
        if (valid) begin
          take      = 1'b1;
          ends      = eof;
          state_nxt = eof ? IDLE : RUN;
          if (sof) begin
            // A new frame start drops the one in progress; this bit is bit 1.
            drops    = 1'b1;
            crc_base = STATE_INIT_VAL;
            cnt_nxt  = ONE_CNT;
          end else begin
            cnt_nxt = (cnt == '1) ? cnt : cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    crc_nxt = crc_step(crc_base, s_in);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // CRC register, bit counter and the pending verdict captured on eof.
  always_ff @(posedge clk) begin
    if (rst) begin
      crc_state  <= STATE_INIT_VAL;
      cnt        <= '0;
      pend       <= 1'b0;
      pend_ok    <= 1'b0;
      pend_runt  <= 1'b0;
      pend_abort <= 1'b0;
      pend_bits  <= '0;
    end else begin
      pend       <= take && ends;
      pend_abort <= drops;
      if (take) begin
        crc_state <= crc_nxt;
        cnt       <= cnt_nxt;
      end
      if (take && ends) begin
        pend_bits <= cnt_nxt;
        pend_runt <= (cnt_nxt < MIN_CNT);
        pend_ok   <= (crc_nxt == RESIDUE) && !(cnt_nxt < MIN_CNT);
      end
    end
  end

  // Output stage: one-cycle pulses, verdict fields held until the next done.
  always_ff @(posedge clk) begin
    if (rst) begin
      done       <= 1'b0;
      aborted    <= 1'b0;
      fcs_ok     <= 1'b0;
      runt       <= 1'b0;
      frame_bits <= '0;
    end else begin
      done    <= pend;
      aborted <= pend_abort;
      if (pend) begin
        fcs_ok     <= pend_ok;
        runt       <= pend_runt;
        frame_bits <= pend_bits;
      end
    end
  end

`ifdef FCS_CHECK_STATS_EN
  // Saturating good/bad verdict counters; dropped frames never reach a verdict.
  always_ff @(posedge clk) begin
    if (rst) begin
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else if (pend) begin
      if (pend_ok) begin
        if (good_cnt != 16'hFFFF) good_cnt <= good_cnt + 1'b1;
      end else begin
        if (bad_cnt != 16'hFFFF) bad_cnt <= bad_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fcs_check.sv
// Bench for fcs_check: directed plus random frames, reference CRC by polynomial long division.
// Two instances (MIN_BITS 32 and 40) share one input stream.
module tb_fcs_check;
  localparam logic [31:0] RES = 32'hC704DD7B;

  logic        clk = 1'b0;
  logic        rst, valid, s_in, sof, eof;
  logic        done, fcs_ok, runt, aborted;
  logic [15:0] frame_bits;
  logic [31:0] crc_state;
  logic        done40, ok40, runt40, ab40;
  logic [15:0] fb40;
  logic [31:0] crc40;
`ifdef FCS_CHECK_STATS_EN
  logic [15:0] good_cnt, bad_cnt, good40, bad40;
`endif

  int checks = 0, errors = 0;
  int done_seen = 0, ok_seen = 0, abort_seen = 0;
  int good_exp = 0, bad_exp = 0;

  always #5 clk = ~clk;

  fcs_check #(.MIN_BITS(32)) dut (
    .clk(clk), .rst(rst), .valid(valid), .s_in(s_in), .sof(sof), .eof(eof),
    .done(done), .fcs_ok(fcs_ok), .runt(runt), .aborted(aborted),
    .frame_bits(frame_bits), .crc_state(crc_state)
`ifdef FCS_CHECK_STATS_EN
    , .good_cnt(good_cnt), .bad_cnt(bad_cnt)
`endif
  );

  fcs_check #(.MIN_BITS(40)) dut40 (
    .clk(clk), .rst(rst), .valid(valid), .s_in(s_in), .sof(sof), .eof(eof),
    .done(done40), .fcs_ok(ok40), .runt(runt40), .aborted(ab40),
    .frame_bits(fb40), .crc_state(crc40)
`ifdef FCS_CHECK_STATS_EN
    , .good_cnt(good40), .bad_cnt(bad40)
`endif
  );

  // Pulse counters for the main instance.
  always @(negedge clk) begin
    if (done) begin
      done_seen = done_seen + 1;
      if (fcs_ok) ok_seen = ok_seen + 1;
    end
    if (aborted) abort_seen = abort_seen + 1;
  end

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Register value after a bit sequence = (B(x)*x^32 + INIT*x^n) mod P,
  // computed by long division of the augmented bit string.
  function automatic logic [31:0] model_crc(input bit bits[$]);
    bit          v[$];
    logic [32:0] r;
    v = bits;
    for (int i = 0; i < 32; i++) v.push_back(1'b0);
    for (int i = 0; i < 32; i++) v[i] = ~v[i];
    r = '0;
    foreach (v[i]) begin
      r = {r[31:0], v[i]};
      if (r[32]) r = r ^ 33'h104C11DB7;
    end
    return r[31:0];
  endfunction

  task automatic send_bit(input bit b, input bit s, input bit e);
    valid = 1'b1; s_in = b; sof = s; eof = e;
    @(posedge clk); #1;
    valid = 1'b0; s_in = 1'b0; sof = 1'b0; eof = 1'b0;
  endtask

  // Send a whole frame; 'gap' idle cycles follow each non-final bit, during
  // which the register must hold the prefix CRC.
  task automatic send_frame(input bit f[$], input int gap);
    bit pre[$];
    for (int i = 0; i < f.size(); i++) begin
      send_bit(f[i], i == 0, i == f.size() - 1);
      pre.push_back(f[i]);
      if (i != f.size() - 1) begin
        for (int g = 0; g < gap; g++) begin
          @(posedge clk); #1;
          chk_w("gap_crc_hold", crc_state, model_crc(pre));
        end
      end
    end
  endtask

  // Called right after the eof strobe has been sampled.
  task automatic expect_verdict(input bit f[$], input string tag, input bit exp_ab);
    logic [31:0] c;
    int          n;
    bit          r32, r40, o32, o40;
    c   = model_crc(f);
    n   = f.size();
    r32 = (n < 32);
    r40 = (n < 40);
    o32 = (c == RES) && !r32;
    o40 = (c == RES) && !r40;
    @(negedge clk);
    chk_b({tag, "_done_early"}, done, 1'b0);
    @(negedge clk);
    chk_b({tag, "_done"}, done, 1'b1);
    chk_b({tag, "_fcs_ok"}, fcs_ok, o32);
    chk_b({tag, "_runt"}, runt, r32);
    chk_b({tag, "_aborted"}, aborted, exp_ab);
    chk_w({tag, "_frame_bits"}, 32'(frame_bits), n);
    chk_w({tag, "_crc_state"}, crc_state, c);
    chk_b({tag, "_done40"}, done40, 1'b1);
    chk_b({tag, "_fcs_ok40"}, ok40, o40);
    chk_b({tag, "_runt40"}, runt40, r40);
    chk_w({tag, "_frame_bits40"}, 32'(fb40), n);
    if (o32) good_exp++; else bad_exp++;
`ifdef FCS_CHECK_STATS_EN
    chk_w({tag, "_good_cnt"}, 32'(good_cnt), good_exp);
    chk_w({tag, "_bad_cnt"}, 32'(bad_cnt), bad_exp);
`endif
    @(negedge clk);
    chk_b({tag, "_done_pulse"}, done, 1'b0);
    chk_b({tag, "_aborted_pulse"}, aborted, 1'b0);
  endtask

  initial begin
    bit          good[$], f[$], one[$];
    string       msg;
    byte         ch;
    logic [31:0] fcs_c, c;
    int          d0, a0, k0, kind, len, idx, gap;

    valid = 1'b0; s_in = 1'b0; sof = 1'b0; eof = 1'b0; rst = 1'b1;
    msg   = "123456789";
    fcs_c = 32'hFC891918;
    for (int i = 0; i < 9; i++) begin
      ch = msg[i];
      for (int k = 7; k >= 0; k--) good.push_back(ch[k]);
    end
    for (int k = 31; k >= 0; k--) good.push_back(fcs_c[k]);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_b("rst_done", done, 1'b0);
    chk_b("rst_fcs_ok", fcs_ok, 1'b0);
    chk_b("rst_runt", runt, 1'b0);
    chk_b("rst_aborted", aborted, 1'b0);
    chk_w("rst_frame_bits", 32'(frame_bits), 32'd0);
    chk_w("rst_crc_state", crc_state, 32'hFFFFFFFF);
`ifdef FCS_CHECK_STATS_EN
    chk_w("rst_good_cnt", 32'(good_cnt), 32'd0);
    chk_w("rst_bad_cnt", 32'(bad_cnt), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // Known-good frame
    send_frame(good, 0);
    expect_verdict(good, "good", 1'b0);
    chk_w("good_bits_104", 32'(frame_bits), 32'd104);
    chk_w("good_residue", crc_state, 32'hC704DD7B);
    chk_b("good_ok_const", fcs_ok, 1'b1);

    // Bit 5 flipped
    f = good;
    f[5] = ~f[5];
    send_frame(f, 0);
    expect_verdict(f, "err", 1'b0);
    chk_b("err_ok_const", fcs_ok, 1'b0);

    // Empty message: 32 zero FCS bits, runt only for MIN_BITS=40
    f.delete();
    for (int i = 0; i < 32; i++) f.push_back(1'b0);
    send_frame(f, 0);
    expect_verdict(f, "empty", 1'b0);
    chk_b("empty_ok32", fcs_ok, 1'b1);
    chk_b("empty_runt40", runt40, 1'b1);
    chk_b("empty_ok40", ok40, 1'b0);

    // Strobe gaps 1/0/0
    send_frame(good, 2);
    expect_verdict(good, "gap", 1'b0);

    // Abort after 20 bits, then a full good frame
    #1;
    a0 = abort_seen; d0 = done_seen;
    for (int i = 0; i < 20; i++) send_bit(good[i], i == 0, 1'b0);
    send_frame(good, 0);
    expect_verdict(good, "abort", 1'b0);
    #1;
    chk_w("abort_pulses", abort_seen - a0, 32'd1);
    chk_w("abort_dones", done_seen - d0, 32'd1);

    // One-bit frame from IDLE
    one.delete(); one.push_back(1'b0);
    send_bit(1'b0, 1'b1, 1'b1);
    expect_verdict(one, "onebit", 1'b0);

    // sof+eof mid-frame: abort and one-bit runt verdict together
    for (int i = 0; i < 10; i++) send_bit(good[i], i == 0, 1'b0);
    one.delete(); one.push_back(1'b1);
    send_bit(1'b1, 1'b1, 1'b1);
    expect_verdict(one, "sofeof", 1'b1);

    // Back-to-back frames: sof on the strobe right after eof
    #1;
    d0 = done_seen; k0 = ok_seen;
    send_frame(good, 0);
    send_frame(good, 0);
    good_exp++;
    expect_verdict(good, "b2b", 1'b0);
    #1;
    chk_w("b2b_dones", done_seen - d0, 32'd2);
    chk_w("b2b_oks", ok_seen - k0, 32'd2);

    // Random frames: good, corrupted, or short raw bit strings
    for (int t = 0; t < 16; t++) begin
      kind = $urandom_range(0, 2);
      f.delete();
      if (kind == 2) begin
        len = $urandom_range(1, 39);
        for (int i = 0; i < len; i++) f.push_back(1'($urandom_range(0, 1)));
      end else begin
        len = $urandom_range(0, 64);
        for (int i = 0; i < len; i++) f.push_back(1'($urandom_range(0, 1)));
        c = ~model_crc(f);
        for (int k = 31; k >= 0; k--) f.push_back(c[k]);
        if (kind == 1) begin
          idx = $urandom_range(0, f.size() - 1);
          f[idx] = ~f[idx];
        end
      end
      gap = $urandom_range(0, 2);
      send_frame(f, gap);
      expect_verdict(f, "rand", 1'b0);
    end

    // Reset at bit 50, then the good frame again
    for (int i = 0; i < 50; i++) send_bit(good[i], i == 0, 1'b0);
    #1;
    d0 = done_seen;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    good_exp = 0; bad_exp = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_w("rstmid_no_done", done_seen - d0, 32'd0);
    chk_w("rstmid_crc", crc_state, 32'hFFFFFFFF);
    chk_w("rstmid_bits", 32'(frame_bits), 32'd0);
    chk_b("rstmid_ok", fcs_ok, 1'b0);
    @(negedge clk);
    send_frame(good, 0);
    expect_verdict(good, "rstmid_good", 1'b0);
    chk_b("rstmid_good_ok", fcs_ok, 1'b1);
`ifdef FCS_CHECK_STATS_EN
    chk_w("rstmid_good_cnt", 32'(good_cnt), 32'd1);
    chk_w("rstmid_bad_cnt", 32'(bad_cnt), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
